ap_ctrl_hs_driver: RTL and testbench

Synthesizable initiator for the ap_ctrl_hs block-level handshake; launches an HLS top (e.g. rgb2gray_top) a programmed number of times. Holds ap_start until ap_ready, tracks in-flight transactions, timestamps each one, and reports per-transaction latency and total run time. Its finish pulse drives the `finish` input of the dataflow monitors, ending a simulation run or a hardware self-test.

---
 rtl/ap_ctrl_hs_driver.sv | 179 +++++++++++++++++
 tb/tb_ap_ctrl_hs_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_hs_driver.sv
// Initiator for the ap_ctrl_hs block-level handshake: launches a kernel a programmed
// number of times, timestamps each start and reports latency and total run time.
module ap_ctrl_hs_driver #(
    parameter int CNT_W        = 32,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] total_cycles,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic             proto_err
);

    localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;
    logic [CNT_W-1:0] cycle_ctr;
    logic [IF_W-1:0]  inflight, inflight_nxt;
    logic             ap_start_nxt;
    logic             fresh, fresh_nxt;
    logic             abort_pend, abort_pend_nxt;
    logic [CNT_W-1:0] ts_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             accept, hs, pop, push;
    logic [CNT_W-1:0] latency;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign hs        = ap_start & ap_ready;
    assign pop       = ap_done & (inflight != '0);
    // A start that has just been raised (or re-raised after a handshake) owns a new timestamp.
    assign push      = ap_start & fresh;
    assign latency   = cycle_ctr - ts_mem[rd_ptr];

    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        inflight_nxt   = inflight;
        ap_start_nxt   = 1'b0;
        abort_pend_nxt = abort_pend;
        if (hs)
            inflight_nxt = inflight_nxt + 1'b1;
        if (pop)
            inflight_nxt = inflight_nxt - 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    abort_pend_nxt = 1'b0;
                    inflight_nxt   = '0;
                    remaining_nxt  = cmd_count;
                    if (cmd_count != '0) begin
                        ap_start_nxt = 1'b1;
                        state_nxt    = ISSUE;
                    end else begin
                        state_nxt = FINISH;
                    end
                end
            end
            ISSUE: begin
                if (hs)
                    remaining_nxt = remaining - 1'b1;
                if (abort && ap_start && !ap_ready)
                    abort_pend_nxt = 1'b1;
                // An abort never cuts a pending start short; it takes effect at the handshake.
                if ((abort || abort_pend) && (!ap_start || ap_ready)) begin
                    remaining_nxt  = '0;
                    abort_pend_nxt = 1'b0;
                end
                if (ap_start && !ap_ready)
                    ap_start_nxt = 1'b1;
                else
                    ap_start_nxt = (remaining_nxt != '0) && (inflight_nxt < IF_W'(MAX_INFLIGHT));
                if (remaining_nxt == '0 && !ap_start_nxt)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (inflight_nxt == '0)
                    state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign fresh_nxt = ap_start_nxt & (~ap_start | hs);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            inflight     <= '0;
            ap_start     <= 1'b0;
            fresh        <= 1'b0;
            abort_pend   <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cycle_ctr    <= '0;
            finish       <= 1'b0;
            issued_cnt   <= '0;
            done_cnt     <= '0;
            total_cycles <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            proto_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            inflight   <= inflight_nxt;
            ap_start   <= ap_start_nxt;
            fresh      <= fresh_nxt;
            abort_pend <= abort_pend_nxt;
            finish     <= (state_nxt == FINISH);
            if (accept) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                cycle_ctr    <= '0;
                issued_cnt   <= '0;
                done_cnt     <= '0;
                total_cycles <= '0;
                last_latency <= '0;
                max_latency  <= '0;
                proto_err    <= 1'b0;
            end else begin
                if (busy)
                    cycle_ctr <= sat_inc(cycle_ctr);
                if (push)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (hs)
                    issued_cnt <= sat_inc(issued_cnt);
                if (pop) begin
                    rd_ptr       <= ptr_inc(rd_ptr);
                    last_latency <= latency;
                    done_cnt     <= sat_inc(done_cnt);
                    if (latency > max_latency)
                        max_latency <= latency;
                end else if (ap_done) begin
                    proto_err <= 1'b1;
                end
                // cycle_ctr reads 0 in the first busy cycle, so +1 gives cycles since accept.
                if (state == FINISH)
                    total_cycles <= sat_inc(cycle_ctr);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            ts_mem[wr_ptr] <= cycle_ctr;
    end

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// Directed bench for ap_ctrl_hs_driver with a reactive kernel model supplying
// ap_ready/ap_done at programmed delays after each start.
module tb_ap_ctrl_hs_driver;

    localparam int CNT_W        = 32;
    localparam int MAX_INFLIGHT = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             abort = 1'b0;
    logic             kready = 1'b0;
    logic             kdone = 1'b0;
    logic             spur_done = 1'b0;
    wire              ap_done = kdone | spur_done;
    logic             cmd_ready, ap_start, busy, finish, proto_err;
    logic [CNT_W-1:0] issued_cnt, done_cnt, total_cycles, last_latency, max_latency;

    int n_chk = 0;
    int n_err = 0;
    int rdy_dly = 0;
    int done_dly = 1;
    int drop_err = 0;
    int infl_err = 0;
    int start_seen = 0;
    int fin_cnt = 0;

    int   kcyc = 0;
    int   s_cyc = 0;
    bit   seen = 1'b0;
    logic prev_start = 1'b0;
    logic prev_ready = 1'b0;
    int   dq[$];
    bit   ok;

    always #5 clock = ~clock;

    ap_ctrl_hs_driver #(.CNT_W(CNT_W), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_count    (cmd_count),
        .abort        (abort),
        .ap_start     (ap_start),
        .ap_ready     (kready),
        .ap_done      (ap_done),
        .busy         (busy),
        .finish       (finish),
        .issued_cnt   (issued_cnt),
        .done_cnt     (done_cnt),
        .total_cycles (total_cycles),
        .last_latency (last_latency),
        .max_latency  (max_latency),
        .proto_err    (proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Kernel: ready rdy_dly cycles after the first start cycle, done done_dly cycles after it.
    initial begin
        forever begin
            @(negedge clock);
            if (prev_start && !prev_ready && !ap_start) drop_err++;
            if (ap_start && dq.size() >= MAX_INFLIGHT) infl_err++;
            if (ap_start) start_seen++;
            if (finish) fin_cnt++;
            kdone  = 1'b0;
            kready = 1'b0;
            if (!busy) begin
                dq.delete();
                seen = 1'b0;
            end else begin
                if (dq.size() > 0 && dq[0] == kcyc) begin
                    kdone = 1'b1;
                    void'(dq.pop_front());
                end
                if (ap_start) begin
                    if (!seen) begin
                        seen  = 1'b1;
                        s_cyc = kcyc;
                    end
                    if (kcyc - s_cyc >= rdy_dly) begin
                        kready = 1'b1;
                        dq.push_back(s_cyc + done_dly);
                        seen = 1'b0;
                    end
                end
            end
            prev_start = ap_start;
            prev_ready = kready;
            kcyc++;
        end
    end

    task automatic run(input int count, input int rd, input int dd);
        rdy_dly    = rd;
        done_dly   = dd;
        drop_err   = 0;
        infl_err   = 0;
        start_seen = 0;
        fin_cnt    = 0;
        cmd_count  = count;
        cmd_valid  = 1'b1;
        @(negedge clock);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_finish(input string tag, output bit found);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (finish) found = 1'b1;
            else @(negedge clock);
        end
        if (!found) check({tag, "_timeout"}, 32'(finish), 1);
    endtask

    task automatic after_finish(input string tag);
        check({tag, "_busy_in_finish"}, 32'(busy), 1);
        @(negedge clock);
        check({tag, "_finish_falls"}, 32'(finish), 0);
        check({tag, "_busy_falls"}, 32'(busy), 0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        repeat (2) @(negedge clock);
        #1;
        check({tag, "_finish_pulses"}, fin_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_ap_start", 32'(ap_start), 0);
        check("rst_finish", 32'(finish), 0);
        check("rst_issued", issued_cnt, 0);
        check("rst_done", done_cnt, 0);
        check("rst_max_lat", max_latency, 0);
        check("rst_proto_err", 32'(proto_err), 0);

        // Single transaction: ready 1 cycle, done 10 cycles after start.
        run(1, 1, 10);
        check("t1_start_after_accept", 32'(ap_start), 1);
        wait_finish("t1", ok);
        if (ok) after_finish("t1");
        check("t1_issued", issued_cnt, 1);
        check("t1_done", done_cnt, 1);
        check("t1_last_lat", last_latency, 10);
        check("t1_max_lat", max_latency, 10);
        check("t1_total", total_cycles, 12);

        // Four transactions, ready on start, done 3 later: inflight limit of 2 exercised.
        run(4, 0, 3);
        wait_finish("t2", ok);
        if (ok) after_finish("t2");
        check("t2_issued", issued_cnt, 4);
        check("t2_done", done_cnt, 4);
        check("t2_proto_err", 32'(proto_err), 0);
        check("t2_start_at_max_inflight", infl_err, 0);
        check("t2_max_lat", max_latency, 3);
        check("t2_total", total_cycles, 10);

        // Zero-length command goes straight to FINISH.
        run(0, 0, 1);
        check("t3_finish", 32'(finish), 1);
        @(negedge clock);
        check("t3_finish_falls", 32'(finish), 0);
        check("t3_cmd_ready", 32'(cmd_ready), 1);
        check("t3_issued", issued_cnt, 0);
        check("t3_done", done_cnt, 0);
        check("t3_no_start", start_seen, 0);

        // Abort during the third start while ap_ready is withheld for 3 cycles.
        run(10, 3, 5);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (issued_cnt == 2 && ap_start) ok = 1'b1;
            else @(negedge clock);
        end
        check("t4_third_start_seen", 32'(ok), 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        wait_finish("t4", ok);
        if (ok) after_finish("t4");
        check("t4_issued", issued_cnt, 3);
        check("t4_done", done_cnt, 3);
        check("t4_start_held", drop_err, 0);
        check("t4_last_lat", last_latency, 5);

        // Spurious done in IDLE sets proto_err and changes nothing else.
        spur_done = 1'b1;
        @(negedge clock);
        spur_done = 1'b0;
        check("t5_proto_err_set", 32'(proto_err), 1);
        check("t5_done_unchanged", done_cnt, 3);
        check("t5_lat_unchanged", last_latency, 5);
        run(2, 0, 2);
        check("t5_proto_err_cleared", 32'(proto_err), 0);
        check("t5_issued_cleared", issued_cnt, 0);
        wait_finish("t5", ok);
        if (ok) after_finish("t5");
        check("t5_issued", issued_cnt, 2);
        check("t5_done", done_cnt, 2);
        check("t5_max_lat", max_latency, 2);
        check("t5_proto_err_end", 32'(proto_err), 0);

        // Reset in DRAIN with one transaction still in flight.
        run(1, 0, 20);
        @(negedge clock);
        check("t6_in_drain", 32'(busy && !ap_start), 1);
        check("t6_issued_pre", issued_cnt, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t6_busy", 32'(busy), 0);
        check("t6_cmd_ready", 32'(cmd_ready), 1);
        check("t6_ap_start", 32'(ap_start), 0);
        check("t6_issued", issued_cnt, 0);
        check("t6_done", done_cnt, 0);
        check("t6_finish", 32'(finish), 0);
        repeat (25) @(negedge clock);
        #1;
        check("t6_no_finish", fin_cnt, 0);
        check("t6_proto_err", 32'(proto_err), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
